rom_ram_delay_env: RTL and testbench
====================================

Name:
rom_ram_delay_env

Overview:
Self-contained data-delay exercise block containing a 16x8 synchronous ROM, a 16x8 RAM and a control sequencer. On a start request it reads every ROM word through a one-cycle registered read path and writes it into the RAM at the same address. The write strobe, address and data are exported for observation, and the block signals completion with a one-cycle done pulse. It sits at the top of the data-delay experiment and is driven by a start/done handshake master.

Parameters:
ADDR_W, 4, address width; depth = 2**ADDR_W = 16
DATA_W, 8, data word width
ROM contents are fixed: rom[k] = (k * 8'h11) mod 2**DATA_W, giving 00,11,22,...,FF.

Ports:
clk        input   1       rising-edge clock
rst        input   1       reset, asynchronous and active-high
start_sig  input   1       level start request
done_sig   output  1       one-cycle completion pulse
write_en   output  1       RAM write strobe, registered
ram_addr   output  ADDR_W  RAM write address, registered
rom_data   output  DATA_W  data being written; registered ROM output

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-high (rst).
- While rst is high:
  - done_sig, write_en, ram_addr and rom_data are 0.
  - The FSM is in IDLE and the address counter is 0.
  - RAM contents are not cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - All outputs are 0.
  - If start_sig is sampled high at an edge (E0), go to RUN with rd_addr = 0.
  - Otherwise stay in IDLE.
- RUN:
  - rd_addr is presented to the ROM each cycle.
  - At each edge the ROM registers rom[rd_addr] and rd_addr increments.
  - After the edge that issues rd_addr = 15, go to DRAIN.
- Data delay pipeline:
  - At edge E(k+1), k = 0..15, the outputs become write_en = 1, ram_addr = k, rom_data = rom[k].
  - ram_addr is rd_addr delayed by one stage so it stays aligned with the ROM data.
- RAM write: at each edge where write_en is high, ram[ram_addr] <= rom_data.
- Write window: write_en is high for exactly 16 consecutive cycles, E1 through E17 exclusive, with addresses 0..15 in ascending order and no gaps.
- DRAIN: covers the final write cycle. At E17, write_en and ram_addr/rom_data return to 0, done_sig goes to 1, and the FSM enters DONE.
- DONE:
  - done_sig is high for exactly one cycle.
  - At E18, done_sig goes to 0 and the FSM returns to IDLE.
- Start handling:
  - start_sig is a level request.
  - Changes to start_sig during RUN, DRAIN or DONE are ignored; a started run always completes.
  - After IDLE is re-entered, a new run begins at the first edge where start_sig is sampled high.
  - If start_sig is held high continuously, runs repeat with exactly one IDLE cycle between the done pulse and the next run's first write, two cycles later.
- Total latency: start sampled at E0 gives done visible after E17, i.e. 17 cycles.
- Address counters wrap modulo 16, but the run terminates before any wrap is used.
- Reset asserted mid-run:
  - Aborts immediately; all outputs are 0 and the FSM is in IDLE.
  - RAM retains whatever was written so far.
  - After reset release, a new run requires start_sig.

Decomposition:
- Package rom_ram_delay_pkg:
  - ADDR_W and DATA_W defaults, and DEPTH.
  - State enum {IDLE, RUN, DRAIN, DONE}.
  - Function rom_word(k) returning k*8'h11.
- Natural sub-module: rom_ram_delay_rom, a synchronous 16x8 ROM with registered output, built from rom_word.
- The RAM array and the FSM stay in the top.

Test Plan:
- Reset: hold rst high 100 cycles with start_sig = 1 -> done_sig, write_en, ram_addr and rom_data are all 0 throughout.
- Single run: raise start_sig at edge E0 -> write_en = 1 for cycles E1..E16; at edge E(k+1), ram_addr = k and rom_data = 8'h11*k (00..FF); done_sig = 1 only in the cycle after E17; RAM (hierarchical check) holds 00,11,...,FF.
- Handshake master loop (drop start for one cycle on seeing done, then re-raise):
  - the second run starts exactly 2 edges after the done cycle;
  - its 16 writes and done pulse are identical to the first run;
  - there is never a second done cycle per run.
- start_sig held high continuously -> periodic runs with period 19 cycles (17 + DONE + IDLE); write_en is never high in DONE or IDLE cycles.
- Drop start_sig low at write 5 -> the run still completes all 16 writes and the done pulse; no new run until start_sig is high again.
- Assert rst at write 8 -> outputs go to 0 asynchronously; after release with start_sig = 1, a full 16-write run restarts from address 0.

Source files
------------

// File: rtl/rom_ram_delay_pkg.sv
// Shared widths, sequencer state encoding and the fixed ROM contents
// for the ROM-to-RAM data-delay block.
package rom_ram_delay_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEPTH      = 2 ** DEF_ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // ROM word k is k * 8'h11; callers truncate to their data width.
    function automatic int unsigned rom_word(input int unsigned k);
        return k * 32'h11;
    endfunction

endpackage

// File: rtl/rom_ram_delay_rom.sv
// Synchronous ROM with a registered output. The output is forced to 0
// whenever no read is enabled so the exported data bus is quiet outside
// the write window.
module rom_ram_delay_rom
    import rom_ram_delay_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    localparam int ROM_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] words [ROM_DEPTH];

    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_word
        assign words[k] = DATA_W'(rom_word(unsigned'(k)));
    end

    // Registered read: one-cycle latency from addr to data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (en) begin
            data <= words[addr];
        end else begin
            data <= '0;
        end
    end

endmodule

// File: rtl/rom_ram_delay_env.sv
// Start/done driven sequencer that copies every ROM word into a RAM at
// the same address. The RAM write port (strobe, address, data) is
// exported so the one-cycle ROM read delay can be observed.
module rom_ram_delay_env
    import rom_ram_delay_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_sig,
    output logic              done_sig,
    output logic              write_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] rom_data
);

    localparam int NWORDS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NWORDS - 1);

    state_t            state;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] ram [NWORDS];

    // ROM reads only while running; its registered output is rom_data.
    rom_ram_delay_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom (
        .clk  (clk),
        .rst  (rst),
        .en   (state == RUN),
        .addr (rd_addr),
        .data (rom_data)
    );

    // Sequencer: write_en/ram_addr trail rd_addr by one stage so they
    // line up with the registered ROM data; done pulses out of DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_addr  <= '0;
            write_en <= 1'b0;
            ram_addr <= '0;
            done_sig <= 1'b0;
        end else begin
            write_en <= 1'b0;
            ram_addr <= '0;
            done_sig <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_sig) begin
                        state   <= RUN;
                        rd_addr <= '0;
                    end
                end
                RUN: begin
                    write_en <= 1'b1;
                    ram_addr <= rd_addr;
                    rd_addr  <= rd_addr + 1'b1;
                    if (rd_addr == LAST_ADDR) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    done_sig <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM write port; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (write_en) begin
            ram[ram_addr] <= rom_data;
        end
    end

endmodule

// File: tb/tb_rom_ram_delay_env.sv
// Scoreboard bench for rom_ram_delay_env: each started run pushes its 16
// expected writes and its done cycle; a negedge monitor pops and compares.
module tb_rom_ram_delay_env;

    logic       clk;
    logic       rst;
    logic       start_sig;
    logic       done_sig;
    logic       write_en;
    logic [3:0] ram_addr;
    logic [7:0] rom_data;

    typedef struct {
        int         cyc;
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    int  cyc    = 0;
    int  n_chk  = 0;
    int  n_err  = 0;

    rom_ram_delay_env dut (
        .clk       (clk),
        .rst       (rst),
        .start_sig (start_sig),
        .done_sig  (done_sig),
        .write_en  (write_en),
        .ram_addr  (ram_addr),
        .rom_data  (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected writes at edges e0+1..e0+16, done visible after edge e0+17.
    task automatic push_run(input int e0);
        wr_t w;
        for (int k = 0; k < 16; k++) begin
            w.cyc  = e0 + 1 + k;
            w.addr = 4'(k);
            w.data = 8'(k * 17);
            wq.push_back(w);
        end
        dq.push_back(e0 + 17);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_sig && n < 40);
        if (!done_sig) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk_ram();
        for (int k = 0; k < 16; k++) chk("ram_word", dut.ram[k], 32'(k * 17));
    endtask

    task automatic chk_drained(input string tag);
        chk(tag, 32'(wq.size() + dq.size()), 32'd0);
    endtask

    // Monitor: compare the write port and done pulse against the scoreboard.
    always @(negedge clk) begin : mon
        wr_t e;
        int  d;
        if (rst) begin
            chk("rst_outputs", {done_sig, write_en, ram_addr, rom_data}, 32'd0);
        end else begin
            if (write_en) begin
                if (wq.size() == 0) begin
                    chk("extra_write", 32'd1, 32'd0);
                end else begin
                    e = wq.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_addr", ram_addr, e.addr);
                    chk("wr_data", rom_data, e.data);
                end
            end else begin
                chk("idle_bus", {ram_addr, rom_data}, 32'd0);
            end
            if (done_sig) begin
                if (dq.size() == 0) begin
                    chk("extra_done", 32'd1, 32'd0);
                end else begin
                    d = dq.pop_front();
                    chk("done_cycle", cyc, d);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int e0;
        rst       = 1'b1;
        start_sig = 1'b1;

        // Long reset with start requested: outputs must stay 0.
        idle_cycles(100);
        rst       = 1'b0;
        start_sig = 1'b0;
        idle_cycles(3);
        chk_drained("idle_after_rst");

        // Single run followed by a handshake-master restart.
        start_sig = 1'b1;
        push_run(cyc + 1);
        wait_done();
        start_sig = 1'b0;
        @(negedge clk);
        start_sig = 1'b1;
        push_run(cyc + 1);
        wait_done();
        start_sig = 1'b0;
        idle_cycles(5);
        chk_drained("handshake_runs");
        chk_ram();

        // Start held high: runs every 19 cycles.
        start_sig = 1'b1;
        e0 = cyc + 1;
        push_run(e0);
        push_run(e0 + 19);
        push_run(e0 + 38);
        while (cyc < e0 + 38) @(negedge clk);
        start_sig = 1'b0;
        while (cyc < e0 + 62) @(negedge clk);
        chk_drained("continuous_runs");

        // Start dropped during the run: run still completes, no new run.
        start_sig = 1'b1;
        e0 = cyc + 1;
        push_run(e0);
        while (!(write_en && ram_addr == 4'd4) && cyc < e0 + 30) @(negedge clk);
        start_sig = 1'b0;
        idle_cycles(40);
        chk_drained("start_dropped");

        // Reset mid-run: async clear, then a fresh run from address 0.
        start_sig = 1'b1;
        e0 = cyc + 1;
        push_run(e0);
        while (!(write_en && ram_addr == 4'd7) && cyc < e0 + 30) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_rst", {done_sig, write_en, ram_addr, rom_data}, 32'd0);
        wq.delete();
        dq.delete();
        idle_cycles(3);
        rst = 1'b0;
        push_run(cyc + 1);
        wait_done();
        start_sig = 1'b0;
        idle_cycles(5);
        chk_drained("restart_after_rst");
        chk_ram();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
